// File: rtl/fixed_point_alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_point_alu_seq_pkg
//  Description : Shared operation and FSM state encodings for the sequential
//                fixed-point ALU and its divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package fixed_point_alu_seq_pkg;

  // Operation select carried on op_in
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_DIV = 3'd3,
    ALU_MIN = 3'd4,
    ALU_MAX = 3'd5,
    ALU_ABS = 3'd6,
    ALU_NEG = 3'd7
  } alu_op_t;

  // Control FSM states of the top level
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/fixed_point_alu_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_point_alu_seq_divider
//  Description : Unsigned restoring divider, one quotient bit per cycle over
//                W cycles. Dividend is {i_dividend_hi, i_dividend_lo}; the
//                quotient is only W bits wide, so o_overflow flags the case
//                where it would not fit (i_dividend_hi >= i_divisor).
//  Revision    : 1.0 - initial release
// ============================================================================
module fixed_point_alu_seq_divider
  import fixed_point_alu_seq_pkg::*;
#(
  parameter int INT_BITS  = 12,
  parameter int FRAC_BITS = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic [INT_BITS+FRAC_BITS-1:0] i_dividend_hi,
  input  logic [INT_BITS+FRAC_BITS-1:0] i_dividend_lo,
  input  logic [INT_BITS+FRAC_BITS-1:0] i_divisor,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [INT_BITS+FRAC_BITS-1:0] o_quotient,
  output logic                          o_overflow
);

  localparam int W = INT_BITS + FRAC_BITS;
  localparam int c_cnt_w = $clog2(W + 1);
  localparam logic [c_cnt_w-1:0] c_steps = c_cnt_w'(W);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [W-1:0]       r_rem;
  logic [W-1:0]       r_q;
  logic [W-1:0]       r_div;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;

  // Partial remainder shifted left with the next dividend bit brought in
  logic [W:0]   w_shifted;
  logic [W-1:0] w_trial;
  logic         w_fits;

  assign w_shifted = {r_rem, r_q[W-1]};
  assign w_fits    = (w_shifted >= {1'b0, r_div});
  assign w_trial   = w_shifted[W-1:0] - r_div;

  // Load on start, then one restoring step per cycle; r_q shifts dividend out and quotient in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= i_dividend_hi;
        r_q    <= i_dividend_lo;
        r_div  <= i_divisor;
        r_cnt  <= c_steps;
        r_busy <= 1'b1;
        r_ovf  <= (i_dividend_hi >= i_divisor);
      end else if (r_busy) begin
        r_rem <= w_fits ? w_trial : w_shifted[W-1:0];
        r_q   <= {r_q[W-2:0], w_fits};
        r_cnt <= r_cnt - c_one;
        if (r_cnt == c_one) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_q;
  assign o_overflow = r_ovf;

endmodule
`default_nettype wire

// File: rtl/fixed_point_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_point_alu_seq
//  Description : Sequential valid/ready fixed-point ALU, signed Q(INT.FRAC).
//                Single-cycle add/sub/min/max/abs/neg, 2-cycle multiply,
//                W+2-cycle divide; all results saturate with flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fixed_point_alu_seq
  import fixed_point_alu_seq_pkg::*;
#(
  parameter int INT_BITS  = 12,
  parameter int FRAC_BITS = 20
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [INT_BITS+FRAC_BITS-1:0] d0_in,
  input  logic [INT_BITS+FRAC_BITS-1:0] d1_in,
  input  logic [2:0]                    op_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic [INT_BITS+FRAC_BITS-1:0] res_out,
  output logic                          gt_out,
  output logic                          eq_out,
  output logic                          ovf_out,
  output logic                          div0_out,
  output logic                          valid_out,
  input  logic                          ready_in
);

  localparam int W = INT_BITS + FRAC_BITS;
  localparam logic [W-1:0] c_max = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] c_min = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] c_max_wide = {{W{1'b0}}, c_max};
  localparam logic signed [2*W-1:0] c_min_wide = {{W{1'b1}}, c_min};

  // Clamp a wide signed value into W bits; returns {clamped, value}
  function automatic logic [W:0] sat_clamp(input logic signed [2*W-1:0] v);
    if (v > c_max_wide)      return {1'b1, c_max};
    else if (v < c_min_wide) return {1'b1, c_min};
    else                     return {1'b0, v[W-1:0]};
  endfunction

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  alu_state_t             r_state;
  logic                   r_ready, r_valid, r_gt, r_eq, r_ovf, r_div0;
  logic [W-1:0]           r_res;
  logic signed [2*W-1:0]  r_prod;
  logic                   r_neg_a, r_neg_q, r_b_zero;

  alu_op_t                w_op;
  logic signed [2*W-1:0]  w_a_wide, w_b_wide;
  logic                   w_accept;
  logic [W:0]             w_fast, w_mul, w_div;
  logic [W-1:0]           w_abs_a, w_abs_b;
  logic [2*W-1:0]         w_dividend;
  logic                   w_div_busy, w_div_done, w_q_ovf;
  logic [W-1:0]           w_q;
  logic signed [W:0]      w_q_signed;
  logic signed [2*W-1:0]  w_q_wide;

  // Asynchronous assert, synchronous deassert of the internal reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_op     = alu_op_t'(op_in);
  assign w_a_wide = {{W{d0_in[W-1]}}, d0_in};
  assign w_b_wide = {{W{d1_in[W-1]}}, d1_in};
  assign w_accept = (r_state == ST_IDLE) && valid_in;

  // Single-cycle operations, evaluated directly on the operand inputs
  always_comb begin
    w_fast = '0;
    case (w_op)
      ALU_ADD: w_fast = sat_clamp(w_a_wide + w_b_wide);
      ALU_SUB: w_fast = sat_clamp(w_a_wide - w_b_wide);
      ALU_MIN: w_fast = {1'b0, (w_b_wide < w_a_wide) ? d1_in : d0_in};
      ALU_MAX: w_fast = {1'b0, (w_b_wide > w_a_wide) ? d1_in : d0_in};
      ALU_ABS: w_fast = sat_clamp(d0_in[W-1] ? -w_a_wide : w_a_wide);
      ALU_NEG: w_fast = sat_clamp(-w_a_wide);
      default: w_fast = '0;
    endcase
  end

  // Floor-scaled product back to Q format
  assign w_mul = sat_clamp(r_prod >>> FRAC_BITS);

  // Divider works on magnitudes; |MIN| still fits as an unsigned W-bit value
  assign w_abs_a    = d0_in[W-1] ? (~d0_in + 1'b1) : d0_in;
  assign w_abs_b    = d1_in[W-1] ? (~d1_in + 1'b1) : d1_in;
  assign w_dividend = {{W{1'b0}}, w_abs_a} << FRAC_BITS;

  fixed_point_alu_seq_divider #(
    .INT_BITS  (INT_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_divider (
    .clk           (clk_in),
    .rst_n         (w_rst_n),
    .i_start       (w_accept && (w_op == ALU_DIV)),
    .i_dividend_hi (w_dividend[2*W-1:W]),
    .i_dividend_lo (w_dividend[W-1:0]),
    .i_divisor     (w_abs_b),
    .o_busy        (w_div_busy),
    .o_done        (w_div_done),
    .o_quotient    (w_q),
    .o_overflow    (w_q_ovf)
  );

  assign w_q_signed = r_neg_q ? -$signed({1'b0, w_q}) : $signed({1'b0, w_q});
  assign w_q_wide   = {{(W-1){w_q_signed[W]}}, w_q_signed};

  // Apply sign to the quotient magnitude; divide-by-zero saturates on A's sign
  always_comb begin
    w_div = '0;
    if (r_b_zero)     w_div = {1'b1, r_neg_a ? c_min : c_max};
    else if (w_q_ovf) w_div = {1'b1, r_neg_q ? c_min : c_max};
    else              w_div = sat_clamp(w_q_wide);
  end

  // Control FSM with registered result, flags and handshake outputs
  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_res    <= '0;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_ovf    <= 1'b0;
      r_div0   <= 1'b0;
      r_prod   <= '0;
      r_neg_a  <= 1'b0;
      r_neg_q  <= 1'b0;
      r_b_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            r_ready <= 1'b0;
            r_gt    <= (w_a_wide > w_b_wide);
            r_eq    <= (d0_in == d1_in);
            case (w_op)
              ALU_MUL: begin
                r_prod  <= w_a_wide * w_b_wide;
                r_state <= ST_MUL;
              end
              ALU_DIV: begin
                r_neg_a  <= d0_in[W-1];
                r_neg_q  <= d0_in[W-1] ^ d1_in[W-1];
                r_b_zero <= (d1_in == '0);
                r_state  <= ST_DIV;
              end
              default: begin
                r_res   <= w_fast[W-1:0];
                r_ovf   <= w_fast[W];
                r_div0  <= 1'b0;
                r_valid <= 1'b1;
                r_state <= ST_DONE;
              end
            endcase
          end
        end
        ST_MUL: begin
          r_res   <= w_mul[W-1:0];
          r_ovf   <= w_mul[W];
          r_div0  <= 1'b0;
          r_valid <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DIV: begin
          if (w_div_done && !w_div_busy) begin
            r_res   <= w_div[W-1:0];
            r_ovf   <= w_div[W];
            r_div0  <= r_b_zero;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ready_in) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_out = r_ready;
  assign valid_out = r_valid;
  assign res_out   = r_res;
  assign gt_out    = r_gt;
  assign eq_out    = r_eq;
  assign ovf_out   = r_ovf;
  assign div0_out  = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fixed_point_alu_seq
//  Description : Directed self-checking bench for fixed_point_alu_seq (Q12.20)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_point_alu_seq;

  localparam int W = 32;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
                         OP_MIN = 3'd4, OP_MAX = 3'd5, OP_ABS = 3'd6, OP_NEG = 3'd7;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   fl;   // {gt, eq, ovf, div0}
  } vec_t;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic [W-1:0] d0_in, d1_in;
  logic [2:0]   op_in;
  logic         valid_in, ready_in;
  logic         ready_out, gt_out, eq_out, ovf_out, div0_out, valid_out;
  logic [W-1:0] res_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_in = ~clk_in;

  fixed_point_alu_seq #(.INT_BITS(12), .FRAC_BITS(20)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .d0_in     (d0_in),
    .d1_in     (d1_in),
    .op_in     (op_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .res_out   (res_out),
    .gt_out    (gt_out),
    .eq_out    (eq_out),
    .ovf_out   (ovf_out),
    .div0_out  (div0_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  // Present one op, accept on the next edge, count edges until valid_out (accept edge = 1)
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int latency);
    op_in = op; d0_in = a; d1_in = b; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    latency = 1;
    while (!valid_out && latency < 100) begin
      @(posedge clk_in); #1;
      latency++;
    end
  endtask

  task automatic consume;
    ready_in = 1'b1;
    @(posedge clk_in); #1;
    ready_in = 1'b0;
  endtask

  task automatic test_reset;
    rst_n_in = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    op_in = 3'd0; d0_in = '0; d1_in = '0;
    #2 rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    n_total++;
    if ({ready_out, valid_out} !== 2'b10)
      $display("FAIL reset_handshake: got ready=%b valid=%b expected ready=1 valid=0", ready_out, valid_out);
    else n_pass++;
    n_total++;
    if ({res_out, gt_out, eq_out, ovf_out, div0_out} !== {32'h0, 4'b0000})
      $display("FAIL reset_outputs: got res=%h flags=%b expected res=0 flags=0000",
               res_out, {gt_out, eq_out, ovf_out, div0_out});
    else n_pass++;
    rst_n_in = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
    n_total++;
    if ({ready_out, valid_out} !== 2'b10)
      $display("FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0", ready_out, valid_out);
    else n_pass++;
  endtask

  task automatic test_single_cycle;
    vec_t v [11] = '{
      '{OP_ADD, 32'h0018_0000, 32'h0010_0000, 32'h0028_0000, 4'b1000},
      '{OP_SUB, 32'h0010_0000, 32'h0018_0000, 32'hFFF8_0000, 4'b0000},
      '{OP_MIN, 32'h0050_0000, 32'h0050_0000, 32'h0050_0000, 4'b0100},
      '{OP_MAX, 32'h0010_0000, 32'hFFF0_0000, 32'h0010_0000, 4'b1000},
      '{OP_MIN, 32'h0010_0000, 32'hFFF0_0000, 32'hFFF0_0000, 4'b1000},
      '{OP_ABS, 32'hFFF0_0000, 32'h0000_0000, 32'h0010_0000, 4'b0000},
      '{OP_ADD, 32'h7FFF_FFFF, 32'h0010_0000, 32'h7FFF_FFFF, 4'b1010},
      '{OP_SUB, 32'h8000_0000, 32'h0010_0000, 32'h8000_0000, 4'b0010},
      '{OP_NEG, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 4'b0010},
      '{OP_ABS, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 4'b0010},
      '{OP_NEG, 32'h0018_0000, 32'h0018_0000, 32'hFFE8_0000, 4'b0100}
    };
    int lat;
    for (int i = 0; i < 11; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, lat);
      n_total++;
      if (lat !== 1)
        $display("FAIL single[%0d] latency: got %0d expected 1", i, lat);
      else n_pass++;
      n_total++;
      if ({res_out, gt_out, eq_out, ovf_out, div0_out} !== {v[i].res, v[i].fl})
        $display("FAIL single[%0d] result: got res=%h flags=%b expected res=%h flags=%b",
                 i, res_out, {gt_out, eq_out, ovf_out, div0_out}, v[i].res, v[i].fl);
      else n_pass++;
      consume();
    end
  endtask

  task automatic test_mul;
    vec_t v [4] = '{
      '{OP_MUL, 32'h0018_0000, 32'h0020_0000, 32'h0030_0000, 4'b0000},
      '{OP_MUL, 32'h7FF0_0000, 32'h0020_0000, 32'h7FFF_FFFF, 4'b1010},
      '{OP_MUL, 32'hFFE8_0000, 32'h0020_0000, 32'hFFD0_0000, 4'b0000},
      '{OP_MUL, 32'hFFFF_FFFF, 32'h0008_0000, 32'hFFFF_FFFF, 4'b0000}
    };
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, lat);
      n_total++;
      if (lat !== 2)
        $display("FAIL mul[%0d] latency: got %0d expected 2", i, lat);
      else n_pass++;
      n_total++;
      if ({res_out, gt_out, eq_out, ovf_out, div0_out} !== {v[i].res, v[i].fl})
        $display("FAIL mul[%0d] result: got res=%h flags=%b expected res=%h flags=%b",
                 i, res_out, {gt_out, eq_out, ovf_out, div0_out}, v[i].res, v[i].fl);
      else n_pass++;
      consume();
    end
  endtask

  task automatic test_div;
    vec_t v [7] = '{
      '{OP_DIV, 32'h0030_0000, 32'h0020_0000, 32'h0018_0000, 4'b1000},
      '{OP_DIV, 32'hFFF0_0000, 32'h0030_0000, 32'hFFFA_AAAB, 4'b0000},
      '{OP_DIV, 32'h0010_0000, 32'h0000_0000, 32'h7FFF_FFFF, 4'b1011},
      '{OP_DIV, 32'hFFF0_0000, 32'h0000_0000, 32'h8000_0000, 4'b0011},
      '{OP_DIV, 32'h7FF0_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1010},
      '{OP_DIV, 32'h8000_0000, 32'h0010_0000, 32'h8000_0000, 4'b0000},
      '{OP_DIV, 32'h8000_0000, 32'hFFF0_0000, 32'h7FFF_FFFF, 4'b0010}
    };
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, lat);
      n_total++;
      if (lat !== 34)
        $display("FAIL div[%0d] latency: got %0d expected 34", i, lat);
      else n_pass++;
      n_total++;
      if ({res_out, gt_out, eq_out, ovf_out, div0_out} !== {v[i].res, v[i].fl})
        $display("FAIL div[%0d] result: got res=%h flags=%b expected res=%h flags=%b",
                 i, res_out, {gt_out, eq_out, ovf_out, div0_out}, v[i].res, v[i].fl);
      else n_pass++;
      consume();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    run_op(OP_ADD, 32'h0010_0000, 32'h0010_0000, lat);
    n_total++;
    if (lat !== 1) $display("FAIL bp_latency: got %0d expected 1", lat);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'b1; op_in = OP_SUB; d0_in = $urandom; d1_in = $urandom;
      n_total++;
      if ({valid_out, ready_out, res_out, ovf_out} !== {2'b10, 32'h0020_0000, 1'b0})
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b res=%h ovf=%b expected valid=1 ready=0 res=00200000 ovf=0",
                 i, valid_out, ready_out, res_out, ovf_out);
      else n_pass++;
      @(posedge clk_in); #1;
    end
    valid_in = 1'b0;
    consume();
    n_total++;
    if ({valid_out, ready_out} !== 2'b01)
      $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", valid_out, ready_out);
    else n_pass++;
    repeat (3) @(posedge clk_in);
    #1;
    n_total++;
    if ({valid_out, ready_out} !== 2'b01)
      $display("FAIL bp_not_queued: got valid=%b ready=%b expected valid=0 ready=1", valid_out, ready_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid_div;
    int lat;
    logic seen_valid;
    op_in = OP_DIV; d0_in = 32'h0030_0000; d1_in = 32'h0020_0000; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    repeat (9) @(posedge clk_in);
    #1;
    rst_n_in = 1'b0;
    #1;
    n_total++;
    if ({valid_out, ready_out, res_out, gt_out, eq_out, ovf_out, div0_out} !== {2'b01, 32'h0, 4'b0000})
      $display("FAIL rst_mid_div: got valid=%b ready=%b res=%h flags=%b expected valid=0 ready=1 res=0 flags=0000",
               valid_out, ready_out, res_out, {gt_out, eq_out, ovf_out, div0_out});
    else n_pass++;
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in); #1;
      if (valid_out) seen_valid = 1'b1;
    end
    n_total++;
    if (seen_valid !== 1'b0)
      $display("FAIL rst_stale_valid: got valid seen=%b expected 0", seen_valid);
    else n_pass++;
    run_op(OP_ADD, 32'h0010_0000, 32'h0008_0000, lat);
    n_total++;
    if (lat !== 1) $display("FAIL rst_add_latency: got %0d expected 1", lat);
    else n_pass++;
    n_total++;
    if ({res_out, gt_out, eq_out, ovf_out, div0_out} !== {32'h0018_0000, 4'b1000})
      $display("FAIL rst_add_result: got res=%h flags=%b expected res=00180000 flags=1000",
               res_out, {gt_out, eq_out, ovf_out, div0_out});
    else n_pass++;
    consume();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
